// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// ----------------
// Merges the CPU writeback stage and the DMA register-load channel onto the
// single RegisterFile write port. CPU writes always win. DMA writes are queued
// in a DEPTH-entry FIFO and drained on cycles where the CPU does not write.
// The output stage is registered, so a selected write reaches rf_* one cycle later.
//
// Optional feature: define RF_ARB_STARVE_GUARD_EN to add the starvation guard.
// After STARVE_MAX consecutive CPU-won cycles with DMA pending, the guard
// stalls the CPU (cpu_stall) for one cycle and forces a DMA slot. Without the
// macro, cpu_stall is tied to 0.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   cpu_we/cpu_addr/cpu_data       CPU writeback request
//   dma_valid/dma_ready            DMA push handshake (valid & ready = push)
//   dma_addr/dma_data              DMA write payload
//   rf_we/rf_addr/rf_data          registered RegisterFile write port
//   dma_pending                    FIFO occupancy
//   cpu_stall                      CPU must hold its writeback this cycle
module rf_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_we,
    input  logic [AW-1:0]              cpu_addr,
    input  logic [DW-1:0]              cpu_data,
    input  logic                       dma_valid,
    output logic                       dma_ready,
    input  logic [AW-1:0]              dma_addr,
    input  logic [DW-1:0]              dma_data,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_addr,
    output logic [DW-1:0]              rf_data,
    output logic [$clog2(DEPTH):0]     dma_pending,
    output logic                       cpu_stall
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    // Holds dma_ready low during reset and for the cycle in which reset releases.
    logic          ready_en_q;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_addr_q, rf_addr_d;
    logic [DW-1:0] rf_data_q, rf_data_d;

    logic fifo_empty_s;
    logic ready_s;
    logic push_s;
    logic pop_s;
    logic stall_s;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;
`endif

    // Selection, FIFO bookkeeping and next-state computation.
    always_comb begin
        fifo_empty_s = (count_q == {CW{1'b0}});
        ready_s      = ready_en_q && (count_q < CW'(DEPTH));
        push_s       = dma_valid && ready_s;
        stall_s      = 1'b0;
`ifdef RF_ARB_STARVE_GUARD_EN
        stall_s      = cpu_we && !fifo_empty_s && (starve_q == SW'(STARVE_MAX));
`endif
        // Pop uses registered occupancy only, so an entry pushed this cycle
        // can never fall through to the output.
        pop_s = !fifo_empty_s && (!cpu_we || stall_s);

        if (cpu_we && !stall_s) begin
            rf_we_d   = 1'b1;
            rf_addr_d = cpu_addr;
            rf_data_d = cpu_data;
        end else if (pop_s) begin
            rf_we_d   = 1'b1;
            rf_addr_d = addr_mem_q[rd_ptr_q];
            rf_data_d = data_mem_q[rd_ptr_q];
        end else begin
            rf_we_d   = 1'b0;
            rf_addr_d = rf_addr_q;
            rf_data_d = rf_data_q;
        end

        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

`ifdef RF_ARB_STARVE_GUARD_EN
        if (fifo_empty_s || pop_s) begin
            starve_d = {SW{1'b0}};
        end else if (cpu_we) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
`endif
    end

    // Control and output registers; reset drops any in-flight write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            ready_en_q <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= {AW{1'b0}};
            rf_data_q  <= {DW{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_en_q <= 1'b1;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    // Starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= {SW{1'b0}};
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    // FIFO storage; no reset needed because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            addr_mem_q[wr_ptr_q] <= dma_addr;
            data_mem_q[wr_ptr_q] <= dma_data;
        end
    end

    assign dma_ready   = ready_s;
    assign rf_we       = rf_we_q;
    assign rf_addr     = rf_addr_q;
    assign rf_data     = rf_data_q;
    assign dma_pending = count_q;
    assign cpu_stall   = stall_s;

endmodule
